seven_seg_scanner: RTL
======================

# seven_seg_scanner

Parametrised multiplexed seven-segment display driver for N digits. It captures per-digit hex nibbles, decimal points, enables and blink flags into shadow registers, and commits them only at frame boundaries so the display never tears. It scans the digits with per-slot dead time and 16-level PWM brightness, blinks selected digits, and drives registered anode and segment lines. It sits between the clock counters and the board display, and is the scalable replacement for the fixed 4-digit hour/minute scanner.

## Interface
- DIGITS, 4: number of digits scanned (2..8).
- SUB_DIV, 3125: clock cycles per PWM sub-slot (≥1). One digit slot is 16*SUB_DIV cycles.
- BLINK_DIV, 32: frames per blink half-period (≥1).
- ANODE_ACTIVE_LOW, 1: 1 means anode lines drive 0 to light a digit.
- SEG_ACTIVE_LOW, 1: 1 means segment and dp lines drive 0 to light.

- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_data  in  4*DIGITS  hex nibble per digit; digit k uses bits [4k+3:4k]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- enable_in  in  DIGITS  per-digit enable; 0 keeps the digit dark.
- blink_in  in  DIGITS  per-digit blink flag.
- load  in  1  strobe; captures all *_in and digit_data into the pending shadow.
- brightness  in  4  number of lit sub-slots per digit slot (0 = dark, 15 = 15/16 duty). Sampled live, not shadowed.
- anode  out  DIGITS  one-hot digit select (polarity per ANODE_ACTIVE_LOW).
- segment  out  7  segment[0]=a … segment[6]=g (polarity per SEG_ACTIVE_LOW).
- dp_out  out  1  decimal point for the current digit.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

## Operation
- Counters:
  - sub_cnt counts 0..SUB_DIV-1.
  - sub_idx (4 bits) increments when sub_cnt wraps, covering 0..15.
  - digit_idx increments when sub_idx wraps from 15, covering 0..DIGITS-1 and wrapping to 0.
  - blink_cnt counts frames 0..BLINK_DIV-1; on its wrap, blink_phase toggles.
- Frame boundary: the cycle in which digit_idx wraps DIGITS-1→0. Internal commit strobe.
- Shadowing:
  - load writes the inputs into pending.
  - The commit strobe copies pending into active.
  - If load and commit occur in the same cycle, the inputs write both pending and active.
  - Multiple loads within a frame: only the last one is kept.
- Lighting: digit d = digit_idx is lit iff all of the following hold:
  - active_enable[d] = 1
  - not (active_blink[d] and blink_phase = 1)
  - sub_idx ≠ 0 (dead time, anti-ghosting)
  - sub_idx ≤ brightness
- Lit digit: anode selects d only; segment = hex decode of the active nibble; dp_out = active_dp[d].
- Unlit: all anodes inactive; segment and dp_out all inactive.
- Hex decode, abcdefg active-high: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Polarity inversion is applied at the output registers.

## Timing
- Reset (asynchronous, while reset_n=0):
  - All counters, blink_phase, pending and active shadows are cleared to 0.
  - anode, segment and dp_out are all inactive; frame_tick = 0.
- After reset release: the display stays dark until a load is committed, because active enable is 0.
- anode, segment, dp_out and frame_tick are registered. They reflect the counter state of the previous cycle (1-cycle latency).
- frame_tick is high in the same output cycle in which digit 0's slot begins, i.e. the first output cycle after a commit.
- Slot length is 16*SUB_DIV cycles. Frame length is DIGITS*16*SUB_DIV cycles.
- Data visible latency after load: from 2 cycles (load coincident with commit) to one frame + 1 cycle.
- brightness changes take effect on the next cycle's lighting decision, with no shadowing.
- Reset asserted mid-frame immediately blanks the outputs. Counters restart from 0 on release.

## Test plan
- DIGITS=4, SUB_DIV=2, BLINK_DIV=2. Hold reset_n=0, then release with no load → anode=4'b1111, segment=7'h7F and dp_out=1 for 3 full frames. frame_tick pulses every 128 cycles.
- Load digit_data=16'h1234, enable=4'hF, brightness=15 → after the next frame_tick:
  - digit 0 shows 4 (abcdefg=0110011), digit 3 shows 1.
  - Each digit is lit for 30 of its 32 slot cycles: sub-slot 0 (2 cycles) is dark.
  - The anode one-hot rotates 0→3.
- brightness=0 → all dark. brightness=4 → each digit lit exactly 8 cycles per slot (sub-slots 1..4).
- Three loads within one frame (values 0x1111, 0x2222, 0x3333) → the next frame shows only 3333. A load on the commit cycle with 0xABCD is displayed in the immediately following frame.
- blink_in=4'b0001 → digit 0 lit for 2 frames and dark for 2 frames, alternating. Digits 1–3 stay steady.
- Assert reset_n=0 mid-slot while digit 2 is lit → outputs inactive within the same cycle (asynchronously). After release, the display stays dark until a new load is committed.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed N-digit seven-segment driver with frame-synchronous
// shadow commit, per-slot dead time, 16-level PWM brightness and per-digit blink.
module seven_seg_scanner #(
  parameter int DIGITS = 4,
  parameter int SUB_DIV = 3125,
  parameter int BLINK_DIV = 32,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     enable_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  load,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segment,
  output logic                  dp_out,
  output logic                  frame_tick
);
  localparam int DW = $clog2(DIGITS);
  localparam int SW = SUB_DIV > 1 ? $clog2(SUB_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  logic [SW-1:0]       sub_cnt;
  logic [3:0]          sub_idx;
  logic [DW-1:0]       digit_idx;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, pend_en, pend_blink;
  logic [DIGITS-1:0]   act_dp, act_en, act_blink;
  logic                sub_wrap, slot_wrap, commit, blink_wrap, at_origin, lit;
  logic [3:0]          nibble;
  logic [6:0]          abc, seg_on;
  always_comb begin
    sub_wrap = sub_cnt == SW'(SUB_DIV - 1);
    slot_wrap = sub_wrap && sub_idx == 4'hF;
    commit = slot_wrap && digit_idx == DW'(DIGITS - 1);
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    at_origin = sub_cnt == '0 && sub_idx == 4'h0 && digit_idx == '0;
    nibble = act_data[{digit_idx, 2'b00} +: 4];
    // sub-slot 0 is always dark so the previous digit's charge can bleed off
    lit = act_en[digit_idx] && !(act_blink[digit_idx] && blink_phase) &&
          sub_idx != 4'h0 && sub_idx <= brightness;
    case (nibble)
      4'h0: abc = 7'b1111110;
      4'h1: abc = 7'b0110000;
      4'h2: abc = 7'b1101101;
      4'h3: abc = 7'b1111001;
      4'h4: abc = 7'b0110011;
      4'h5: abc = 7'b1011011;
      4'h6: abc = 7'b1011111;
      4'h7: abc = 7'b1110000;
      4'h8: abc = 7'b1111111;
      4'h9: abc = 7'b1111011;
      4'hA: abc = 7'b1110111;
      4'hB: abc = 7'b0011111;
      4'hC: abc = 7'b1001110;
      4'hD: abc = 7'b0111101;
      4'hE: abc = 7'b1001111;
      default: abc = 7'b1000111;
    endcase
    seg_on = '0;
    for (int i = 0; i < 7; i++) seg_on[i] = abc[6-i];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_cnt <= '0;
      sub_idx <= 4'h0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      pend_data <= '0;
      pend_dp <= '0;
      pend_en <= '0;
      pend_blink <= '0;
      act_data <= '0;
      act_dp <= '0;
      act_en <= '0;
      act_blink <= '0;
      anode <= AN_OFF;
      segment <= SEG_OFF;
      dp_out <= SEG_ACTIVE_LOW;
      frame_tick <= 1'b0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) sub_idx <= sub_idx + 4'h1;
      if (slot_wrap) digit_idx <= commit ? '0 : digit_idx + 1'b1;
      if (commit) blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (commit && blink_wrap) blink_phase <= ~blink_phase;
      if (load) begin
        pend_data <= digit_data;
        pend_dp <= dp_in;
        pend_en <= enable_in;
        pend_blink <= blink_in;
      end
      // a load landing on the commit cycle bypasses pending straight into active
      if (commit) begin
        act_data <= load ? digit_data : pend_data;
        act_dp <= load ? dp_in : pend_dp;
        act_en <= load ? enable_in : pend_en;
        act_blink <= load ? blink_in : pend_blink;
      end
      anode <= lit ? (DIGITS'(1) << digit_idx) ^ AN_OFF : AN_OFF;
      segment <= lit ? seg_on ^ SEG_OFF : SEG_OFF;
      dp_out <= (lit && act_dp[digit_idx]) ^ SEG_ACTIVE_LOW;
      frame_tick <= at_origin;
    end
  end
endmodule
